// File: rtl/serial_pkg.sv
// Shared constants for the serial link (RX and TX paths): baud divisor helper,
// receiver FSM state encoding and bit positions inside the 32-bit status word.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int unsigned QS_NOT_EMPTY  = 31;
    localparam int unsigned QS_OVERRUN    = 30;
    localparam int unsigned QS_FRAME_ERR  = 29;
    localparam int unsigned QS_PARITY_ERR = 28;
    localparam int unsigned QS_COUNT_LSB  = 8;
    localparam int unsigned QS_HEAD_LSB   = 0;

    // Clock cycles per serial bit; callers keep the ratio integral and >= 4.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/serial_rx_port_if.sv
// Datapath-side bundle of the serial receive port: line input, pop/clear
// strobes and the status/data word.
interface serial_rx_port_if;
    logic        rx;
    logic        rd;
    logic        clr;
    logic [31:0] qS;

    modport master (output rx, output rd, output clr, input qS);
    modport slave  (input rx, input rd, input clr, output qS);
endinterface

// File: rtl/serial_rx_fifo.sv
// Synchronous byte FIFO for the serial receiver. A push on a full FIFO is
// accepted only when a pop happens in the same cycle; a pop on empty is ignored.
module serial_rx_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [7:0]    head
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Qualify strobes against the current occupancy.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        head    = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_rx_port.sv
// Serial receive port: 2-flop rx synchronizer, baud counter, frame FSM,
// byte FIFO and status/data word.
// Optional macro SERIAL_RX_PARITY_EN selects 8E1 framing (default 8N1).
module serial_rx_port
    import serial_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    serial_rx_port_if.slave  bus
);

    localparam int unsigned CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned BCW  = $clog2(CPB);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    rx_state_t       state;
    logic [BCW-1:0]  cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            bit_tick;
    logic            stop_sample;
    logic            push;
    logic            frame_set;
    logic            par_set;
    logic            ovr_set;
    logic            ovr_flag;
    logic            frm_flag;
    logic            par_flag;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [7:0]      head;
    logic [31:0]     qs;
`ifdef SERIAL_RX_PARITY_EN
    logic            par_bad;
`endif

    // Bring rx into the clock domain; presets keep an idle-high line quiet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Stop-sample strobes are decoded from FSM state so the byte lands in the
    // FIFO on the stop-sample edge itself (qS shows it the following cycle).
    always_comb begin
        bit_tick    = (cnt == BCW'(CPB - 1));
        stop_sample = (state == ST_STOP) && bit_tick;
        frame_set   = stop_sample && !rx_s2;
`ifdef SERIAL_RX_PARITY_EN
        push        = stop_sample && rx_s2 && !par_bad;
        par_set     = stop_sample && rx_s2 && par_bad;
`else
        push        = stop_sample && rx_s2;
        par_set     = 1'b0;
`endif
        ovr_set     = push && full && !bus.rd;
    end

    // Frame FSM: start detect, mid-bit sampling, LSB-first shift, stop check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state   <= ST_START;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == BCW'(HALF - 1)) begin
                        cnt   <= '0;
                        state <= rx_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + BCW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + BCW'(1);
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_bad <= (^shreg) ^ rx_s2;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + BCW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + BCW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as clr wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_flag <= 1'b0;
            frm_flag <= 1'b0;
            par_flag <= 1'b0;
        end else begin
            ovr_flag <= ovr_set   || (ovr_flag && !bus.clr);
            frm_flag <= frame_set || (frm_flag && !bus.clr);
            par_flag <= par_set   || (par_flag && !bus.clr);
        end
    end

    serial_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus.rd),
        .din   (shreg),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    // Assemble the status/data word.
    always_comb begin
        qs                          = '0;
        qs[QS_NOT_EMPTY]            = !empty;
        qs[QS_OVERRUN]              = ovr_flag;
        qs[QS_FRAME_ERR]            = frm_flag;
        qs[QS_PARITY_ERR]           = par_flag;
        qs[QS_COUNT_LSB +: CW]      = count;
        qs[QS_HEAD_LSB +: 8]        = empty ? 8'h00 : head;
    end

    assign bus.qS = qs;

endmodule

// File: tb/tb_serial_rx_port.sv
// Bench for serial_rx_port at 16 clocks per bit, FIFO depth 4.
// Honours SERIAL_RX_PARITY_EN (8E1 framing plus a bad-parity case).
module tb_serial_rx_port;

    localparam int unsigned DEPTH = 4;
    localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Drive index (within a frame) of the cycle whose closing edge samples stop.
    localparam int EV = 10 + CPB * (NB - 1);

    logic clk = 1'b0;
    logic reset;

    serial_rx_port_if bus ();

    serial_rx_port #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: byte queue plus three sticky flags.
    byte unsigned mq[$];
    logic m_ovr = 1'b0;
    logic m_frm = 1'b0;
    logic m_par = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    string phase = "reset";

    function automatic logic [31:0] model_qs();
        logic [31:0] w;
        w        = '0;
        w[31]    = (mq.size() != 0);
        w[30]    = m_ovr;
        w[29]    = m_frm;
        w[28]    = m_par;
        w[15:8]  = 8'(mq.size());
        w[7:0]   = (mq.size() != 0) ? mq[0] : 8'h00;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: qS=%h expected %h", name, got, exp);
        end
    endtask

    // One clock: apply inputs for the next edge, advance the model across that
    // edge, then compare on the following falling edge.
    // evt: 0 none, 1 good frame completes, 2 bad stop bit, 3 bad parity.
    task automatic tick(input logic rxv, input logic rdv, input logic clrv,
                        input int evt, input byte unsigned d);
        logic ov;
        logic fe;
        logic pe;
        ov = 1'b0;
        fe = 1'b0;
        pe = 1'b0;
        bus.rx  = rxv;
        bus.rd  = rdv;
        bus.clr = clrv;
        if (rdv && mq.size() != 0) void'(mq.pop_front());
        case (evt)
            1: if (mq.size() < DEPTH) mq.push_back(d); else ov = 1'b1;
            2: fe = 1'b1;
            3: pe = 1'b1;
            default: ;
        endcase
        m_ovr = ov || (m_ovr && !clrv);
        m_frm = fe || (m_frm && !clrv);
        m_par = pe || (m_par && !clrv);
        @(negedge clk);
        check(phase, bus.qS, model_qs());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic pop1();
        tick(1'b1, 1'b1, 1'b0, 0, 8'h00);
    endtask

    task automatic clr1();
        tick(1'b1, 1'b0, 1'b1, 0, 8'h00);
    endtask

    // Send one frame LSB first; rd_at pulses rd at that drive index,
    // abort_at stops driving the frame early (both -1 when unused).
    task automatic send(input byte unsigned d, input logic stop_v, input logic par_flip,
                        input int rd_at, input int abort_at);
        logic [10:0] fr;
        int evt;
        fr = '0;
        fr[0]   = 1'b0;
        fr[8:1] = d;
`ifdef SERIAL_RX_PARITY_EN
        fr[9]   = (^d) ^ par_flip;
        fr[10]  = stop_v;
`else
        fr[9]   = stop_v;
`endif
        for (int i = 0; i < NB * CPB; i++) begin
            if (i == abort_at) break;
            evt = 0;
            if (i == EV) evt = !stop_v ? 2 : (par_flip ? 3 : 1);
            tick(fr[i / CPB], (i == rd_at), 1'b0, evt, d);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        bus.clr = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_frm = 1'b0;
        m_par = 1'b0;
        #1;
        check("reset_lit", bus.qS, 32'h0000_0000);
        idle(3);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        bus.rx  = 1'b1;
        bus.rd  = 1'b0;
        bus.clr = 1'b0;
        #1;
        check("reset_lit", bus.qS, 32'h0000_0000);
        @(negedge clk);
        idle(2);
        reset = 1'b1;
        idle(8);

        phase = "a5";
        send(8'hA5, 1'b1, 1'b0, -1, -1);
        check("a5_lit", bus.qS, 32'h8000_01A5);
        pop1();
        check("a5_pop_lit", bus.qS, 32'h0000_0000);
        idle(8);

        phase = "overrun";
        for (int b = 1; b <= 5; b++) begin
            send(8'(b), 1'b1, 1'b0, -1, -1);
            idle(4);
        end
        check("overrun_lit", bus.qS, 32'hC000_0401);
        clr1();
        check("clr_lit", bus.qS, 32'h8000_0401);
        for (int k = 0; k < 4; k++) pop1();
        pop1();
        check("drain_lit", bus.qS, 32'h0000_0000);
        idle(4);

        phase = "frame_err";
        send(8'h3C, 1'b0, 1'b0, -1, -1);
        idle(8);
        check("frame_err_lit", bus.qS, 32'h2000_0000);
        clr1();
        idle(4);

        phase = "glitch";
        for (int k = 0; k < 7; k++) tick(1'b0, 1'b0, 1'b0, 0, 8'h00);
        idle(40);
        check("glitch_lit", bus.qS, 32'h0000_0000);
        send(8'h77, 1'b1, 1'b0, -1, -1);
        check("after_glitch_lit", bus.qS, 32'h8000_0177);
        pop1();
        idle(4);

        phase = "full_rd";
        for (int b = 0; b < 4; b++) begin
            send(8'(8'h10 + b), 1'b1, 1'b0, -1, -1);
            idle(4);
        end
        send(8'h14, 1'b1, 1'b0, EV, -1);
        check("full_rd_lit", bus.qS, 32'h8000_0411);
        for (int k = 0; k < 4; k++) pop1();
        check("full_rd_drain_lit", bus.qS, 32'h0000_0000);
        idle(4);

        phase = "mid_reset";
        send(8'h00, 1'b1, 1'b0, -1, 60);
        do_reset();
        idle(40);
        send(8'h5A, 1'b1, 1'b0, -1, -1);
        check("mid_reset_lit", bus.qS, 32'h8000_015A);
        pop1();
        idle(4);

`ifdef SERIAL_RX_PARITY_EN
        phase = "parity";
        send(8'hC3, 1'b1, 1'b1, -1, -1);
        idle(4);
        check("parity_lit", bus.qS, 32'h1000_0000);
        clr1();
        idle(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
